// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer: releases per-domain active-low resets in order after
// the global reset or a software re-sequence request, then flags when all are released.
module rst_sequencer #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned DLY_W      = 16,
  parameter int unsigned STAGE_DLY  = 1000,
  parameter int unsigned SOFT_HOLD  = 16
) (
  input  logic                  i_clk,
  input  logic                  RST_n,
  input  logic                  i_soft_rst_req,
  output logic [NUM_STAGES-1:0] o_stage_rst_n,
  output logic                  o_all_ready,
  output logic                  o_busy
);

  localparam int unsigned       IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [DLY_W-1:0]  STAGE_LAST = DLY_W'(STAGE_DLY - 1);
  localparam logic [DLY_W-1:0]  SOFT_LAST  = DLY_W'(SOFT_HOLD - 1);

  typedef enum logic [1:0] {StHold, StRelease, StSoft, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [DLY_W-1:0]      r_cnt, w_cnt_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [NUM_STAGES-1:0] r_stage_rst_n, w_stage_rst_n_d;
  logic                  r_all_ready, w_all_ready_d;

  always_ff @(posedge i_clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= StHold;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_stage_rst_n <= '0;
      r_all_ready   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_idx         <= w_idx_d;
      r_stage_rst_n <= w_stage_rst_n_d;
      r_all_ready   <= w_all_ready_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_idx_d         = r_idx;
    w_stage_rst_n_d = r_stage_rst_n;
    w_all_ready_d   = r_all_ready;

    // A soft request overrides whatever the current state would do on this edge.
    if (i_soft_rst_req) begin
      w_state_d       = StSoft;
      w_cnt_d         = '0;
      w_idx_d         = '0;
      w_stage_rst_n_d = '0;
      w_all_ready_d   = 1'b0;
    end else begin
      unique case (r_state)
        StHold: begin
          w_state_d = StRelease;
          w_cnt_d   = '0;
        end
        StRelease: begin
          if (r_cnt == STAGE_LAST) begin
            // OR-ing in one bit at a time keeps the vector thermometer-coded.
            w_stage_rst_n_d = r_stage_rst_n | (NUM_STAGES'(1) << r_idx);
            w_cnt_d         = '0;
            if (r_idx == LAST_IDX) begin
              w_state_d = StDone;
            end else begin
              w_idx_d = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_d = r_cnt + DLY_W'(1);
          end
        end
        StSoft: begin
          if (r_cnt == SOFT_LAST) begin
            w_state_d = StRelease;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + DLY_W'(1);
          end
        end
        StDone: begin
          w_all_ready_d = 1'b1;
        end
        default: begin
          w_state_d = StHold;
        end
      endcase
    end
  end

  assign o_stage_rst_n = r_stage_rst_n;
  assign o_all_ready   = r_all_ready;
  assign o_busy        = (r_state != StDone);

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized scoreboard bench for rst_sequencer: a timeline model pushes expected outputs per
// edge and a negedge monitor pops and compares them.
module tb_rst_sequencer;

  localparam int NS = 3;
  localparam int SD = 4;
  localparam int SH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          soft_req = 1'b0;
  logic [NS-1:0] stage_rst_n;
  logic          all_ready;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // Model state: absolute edge count, edge where release began, and "sitting in reset/hold".
  int t = 0;
  int e_edge = 0;
  bit hold = 1'b1;

  logic [NS+1:0] exp_q[$];

  rst_sequencer #(
    .NUM_STAGES(NS),
    .DLY_W     (8),
    .STAGE_DLY (SD),
    .SOFT_HOLD (SH)
  ) dut (
    .i_clk         (clk),
    .RST_n         (rst_n),
    .i_soft_rst_req(soft_req),
    .o_stage_rst_n (stage_rst_n),
    .o_all_ready   (all_ready),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, t, act, exp);
    end
  endtask

  // Expected {busy, all_ready, stage_rst_n} from elapsed time since the release start.
  function automatic logic [NS+1:0] model_out();
    int d;
    int k;
    logic [NS-1:0] st;
    if (hold || t < e_edge) return {1'b1, 1'b0, {NS{1'b0}}};
    d = t - e_edge;
    k = d / SD;
    if (k > NS) k = NS;
    st = NS'((1 << k) - 1);
    return {(d < NS * SD), (d >= NS * SD + 1), st};
  endfunction

  // One clock: drive inputs, take the edge, update model, optionally drop reset mid-cycle.
  task automatic step(input bit req, input bit rstn, input bit drop);
    @(negedge clk);
    #1;
    soft_req = req;
    rst_n    = rstn;
    @(posedge clk);
    #1;
    t++;
    if (!rstn) begin
      hold = 1'b1;
    end else if (req) begin
      e_edge = t + SH;
      hold   = 1'b0;
    end else if (hold) begin
      e_edge = t;
      hold   = 1'b0;
    end
    if (drop) begin
      #1;
      rst_n = 1'b0;
      hold  = 1'b1;
      #1;
      check("async_stage", 8'(stage_rst_n), 8'd0);
      check("async_ready", 8'(all_ready), 8'd0);
      check("async_busy", 8'(busy), 8'd1);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic scen(input int soft_a, input int soft_b, input int drop_at, input int len);
    for (int e = 0; e < len; e++) begin
      step((e >= soft_a) && (e <= soft_b), 1'b1, e == drop_at);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [NS+1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stage_rst_n", 8'(stage_rst_n), 8'(e[NS-1:0]));
        check("all_ready", 8'(all_ready), 8'(e[NS]));
        check("busy", 8'(busy), 8'(e[NS+1]));
      end
    end
  end

  initial begin : stim
    int low_cnt;
    int r;
    #1 rst_n = 1'b0;
    #1;
    check("reset_stage", 8'(stage_rst_n), 8'd0);
    check("reset_ready", 8'(all_ready), 8'd0);
    check("reset_busy", 8'(busy), 8'd1);
    hold_reset(2);

    scen(20, 20, -1, 40);   // power-up 4/8/12/13, then soft in DONE at 20
    hold_reset(2);
    scen(-1, -1, 5, 6);     // reset dropped between edges 5 and 6
    hold_reset(2);
    scen(-1, -1, -1, 16);   // re-release timing repeats
    hold_reset(2);
    scen(6, 6, -1, 24);     // soft after stage 0 released
    hold_reset(2);
    scen(20, 24, -1, 36);   // soft held across several edges
    hold_reset(2);
    scen(12, 12, -1, 24);   // soft on the final-release edge wins

    low_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (low_cnt > 0) begin
        hold_reset(1);
        low_cnt--;
      end else if (r == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        low_cnt = int'($urandom_range(1, 3));
      end else begin
        step(r < 5, 1'b1, 1'b0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset-release sequencer that sits directly downstream of the chip's reset synchronizer. It takes the synchronized global reset and releases the per-subsystem resets in a fixed order, with a programmable gap between each release. The order is: sensor/SPI first, then UART/command path, then motion/PWM. The block also supports a software-requested re-sequence, and it flags when every stage is out of reset.

## Interface
Parameters:
- NUM_STAGES, default 3: number of independently released reset domains (≥1).
- DLY_W, default 16: width of the internal cycle counter.
- STAGE_DLY, default 1000: clk cycles between successive stage releases (1 ≤ STAGE_DLY < 2^DLY_W).
- SOFT_HOLD, default 16: clk cycles all stages are held in reset after a soft request (1 ≤ SOFT_HOLD < 2^DLY_W).

Ports:
- clk, input, 1: system clock; all logic is on posedge.
- RST_n, input, 1: reset, asynchronous, active-low. It is driven by the synchronized global reset.
- soft_rst_req, input, 1: synchronous soft re-sequence request, sampled on every posedge.
- stage_rst_n, output, NUM_STAGES: per-domain active-low resets. Bit 0 is released first.
- all_ready, output, 1: registered; high only when every stage is released and the sequence is complete.
- busy, output, 1: combinational from state; high in HOLD, SOFT and RELEASE.

## Operation
- State machine states: HOLD, RELEASE, SOFT, DONE.
- Registers: state, cnt[DLY_W-1:0], idx (stage pointer), stage_rst_n, all_ready.
- Reset (RST_n low), asynchronous:
  - state=HOLD, cnt=0, idx=0.
  - stage_rst_n = all 0, all_ready=0.
- HOLD: on the first posedge with RST_n high, go to RELEASE with cnt=0.
- RELEASE, on each posedge:
  - If cnt==STAGE_DLY-1: set stage_rst_n[idx]=1, cnt=0, idx++.
  - If that released bit NUM_STAGES-1: go to DONE.
  - Otherwise: cnt++.
- DONE: set all_ready=1 on the entry edge+1, i.e. registered one cycle after the last release. Hold there until a soft request or RST_n.
- SOFT, entered from any state when soft_rst_req=1 is sampled:
  - On that edge: stage_rst_n = all 0, all_ready=0, idx=0, cnt=0.
  - While in SOFT with no new request: if cnt==SOFT_HOLD-1, go to RELEASE with cnt=0; otherwise cnt++.
- A request sampled while already in SOFT restarts the hold (cnt=0).
- A soft request has priority over a release or DONE transition on the same edge.
- Released bits never re-assert individually. Stages only re-enter reset all together, via RST_n or a soft request.
- stage_rst_n is always thermometer-coded (bits 0..k released, all others low).

## Timing
- Let E be the edge on which RELEASE is entered.
  - Stage k releases at edge E+(k+1)·STAGE_DLY.
  - all_ready rises at edge E+NUM_STAGES·STAGE_DLY+1.
- Power-up: E is the first posedge after RST_n deasserts.
- Soft request sampled at edge S: stage_rst_n goes all 0 after S, and E = S+SOFT_HOLD.
- RST_n assertion mid-sequence: all outputs go to reset values immediately (no clock needed). Deassertion restarts the full sequence.
- All outputs are glitch-free registers, except busy, which is a decode of the state register only.

## Test plan
All scenarios use NUM_STAGES=3, STAGE_DLY=4, SOFT_HOLD=2. Edge 0 is the first posedge with RST_n high.
- Power-up → stage_rst_n is 000 through edge 3, 001 at edge 4, 011 at 8, 111 at 12; all_ready=1 at 13; busy=0 from 12.
- RST_n dropped between edges 5 and 6 → stage_rst_n=000 and all_ready=0 immediately. After re-release at a new edge 0, the timing repeats 4/8/12/13 exactly.
- soft_rst_req pulse at edge 20 (in DONE) → 000 and all_ready=0 after edge 20; 001 at 26, 011 at 30, 111 at 34; all_ready at 35.
- soft_rst_req at edge 6 (stage 0 already released at 4) → 000 after edge 6; 001 at 12, 011 at 16, 111 at 20.
- soft_rst_req held high at edges 20–24 → outputs stay 000; RELEASE entered at edge 26; 001 at 30.
- soft_rst_req at edge 12 (same edge as the last release) → soft wins: stage_rst_n=000 after edge 12, and all_ready never rises; 001 at 18.
